// File: rtl/qrd_pkg.sv
// Shared types, defaults and helpers for the QR-decomposition array front end.
package qrd_pkg;

  localparam int unsigned N_DEF = 4;
  localparam int unsigned W_DEF = 14;

  // One complex sample at the default component width.
  typedef struct packed {
    logic signed [W_DEF-1:0] r;
    logic signed [W_DEF-1:0] i;
  } cplx_t;

  // LSB position of a lane inside a packed multi-lane vector.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/qrd_delay_line.sv
// Enabled shift register of DEPTH stages; q is the last stage.
module qrd_delay_line
  import qrd_pkg::*;
#(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one position per enabled cycle; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/qrd_skew_feeder.sv
// Skews augmented-matrix columns into N row streams for the systolic QR array,
// tagging each row's diagonal element and checking frame length.
module qrd_skew_feeder
  import qrd_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [N*W-1:0] s_col_r,
  input  logic [N*W-1:0] s_col_i,
  input  logic           s_last,
  input  logic           m_ready,
  output logic [N*W-1:0] m_row_r,
  output logic [N*W-1:0] m_row_i,
  output logic [N-1:0]   m_row_valid,
  output logic [N-2:0]   m_row_f,
  output logic           err_frame
);

  localparam int unsigned COLS = N + 1;
  localparam int unsigned CW   = $clog2(COLS);

  logic [CW-1:0] col;
  logic          accept;
  logic          col_end;

  // The whole pipeline moves in lockstep with the array, so readiness is just m_ready.
  assign s_ready = m_ready;
  assign accept  = s_valid && m_ready;
  assign col_end = (col == CW'(COLS - 1));

  // Column counter and sticky frame-length check; s_last and the final column must coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      err_frame <= 1'b0;
    end else if (accept) begin
      if (s_last || col_end) col <= '0;
      else                   col <= col + CW'(1);
      if (s_last != col_end) err_frame <= 1'b1;
    end
  end

  for (genvar j = 0; j < int'(N); j++) begin : g_row
    localparam int unsigned LSB = lane_lsb(j, W);

    if (j < int'(N) - 1) begin : g_tag
      logic [2*W+1:0] d;
      logic [2*W+1:0] q;
      logic           tag;

      assign tag = (col == CW'(j));
      // Bubbles enter as all-zero so downstream sees clean data on invalid beats.
      assign d   = s_valid ? {1'b1, tag, s_col_r[LSB +: W], s_col_i[LSB +: W]} : '0;

      qrd_delay_line #(.DEPTH(j + 1), .WIDTH(2*W + 2)) u_dl (
        .clk (clk),
        .rst (rst),
        .en  (m_ready),
        .d   (d),
        .q   (q)
      );

      assign m_row_valid[j]    = q[2*W+1];
      assign m_row_f[j]        = q[2*W];
      assign m_row_r[LSB +: W] = q[2*W-1:W];
      assign m_row_i[LSB +: W] = q[W-1:0];
    end else begin : g_notag
      // The last row never reaches a flagged diagonal, so it carries no flag bit.
      logic [2*W:0] d;
      logic [2*W:0] q;

      assign d = s_valid ? {1'b1, s_col_r[LSB +: W], s_col_i[LSB +: W]} : '0;

      qrd_delay_line #(.DEPTH(j + 1), .WIDTH(2*W + 1)) u_dl (
        .clk (clk),
        .rst (rst),
        .en  (m_ready),
        .d   (d),
        .q   (q)
      );

      assign m_row_valid[j]    = q[2*W];
      assign m_row_r[LSB +: W] = q[2*W-1:W];
      assign m_row_i[LSB +: W] = q[W-1:0];
    end
  end

endmodule

// File: tb/tb_qrd_skew_feeder.sv
// Directed scoreboard bench for qrd_skew_feeder at N=4, W=14.
module tb_qrd_skew_feeder;
  import qrd_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned WD = 14;
  localparam int unsigned NC = NR + 1;

  typedef struct packed {
    logic  v;
    logic  f;
    cplx_t d;
  } ent_t;

  logic              clk;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [NR*WD-1:0]  s_col_r;
  logic [NR*WD-1:0]  s_col_i;
  logic              s_last;
  logic              m_ready;
  logic [NR*WD-1:0]  m_row_r;
  logic [NR*WD-1:0]  m_row_i;
  logic [NR-1:0]     m_row_valid;
  logic [NR-2:0]     m_row_f;
  logic              err_frame;

  qrd_skew_feeder #(.N(NR), .W(WD)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_col_r     (s_col_r),
    .s_col_i     (s_col_i),
    .s_last      (s_last),
    .m_ready     (m_ready),
    .m_row_r     (m_row_r),
    .m_row_i     (m_row_i),
    .m_row_valid (m_row_valid),
    .m_row_f     (m_row_f),
    .err_frame   (err_frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic signed [WD-1:0] mat_r [NR][NC];
  logic signed [WD-1:0] mat_i [NR][NC];

  ent_t sb_q [NR][$];
  ent_t held [NR];
  int   m_col;
  logic m_err;

  task automatic chk(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  function automatic ent_t get_obs(input int j);
    ent_t e;
    e.v   = m_row_valid[j];
    e.f   = (j < NR - 1) ? m_row_f[j] : 1'b0;
    e.d.r = m_row_r[j*WD +: WD];
    e.d.i = m_row_i[j*WD +: WD];
    return e;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < NR; j++) begin
      sb_q[j].delete();
      for (int k = 0; k < j; k++) sb_q[j].push_back('0);
      held[j] = '0;
    end
    m_col = 0;
    m_err = 1'b0;
  endtask

  // One clock: drive column k (+off) or a bubble, push expectations, then check outputs.
  task automatic step(input logic sv, input int k, input int off, input logic last, input logic mr);
    ent_t e;
    ent_t o;
    logic is_end;
    s_valid = sv;
    s_last  = sv & last;
    m_ready = mr;
    for (int j = 0; j < NR; j++) begin
      if (sv) begin
        s_col_r[j*WD +: WD] = WD'(int'(mat_r[j][k]) + off);
        s_col_i[j*WD +: WD] = WD'(int'(mat_i[j][k]) + off);
      end else begin
        s_col_r[j*WD +: WD] = WD'($urandom);
        s_col_i[j*WD +: WD] = WD'($urandom);
      end
    end
    #1;
    chk("s_ready", 0, 64'(s_ready), 64'(mr));
    if (mr) begin
      for (int j = 0; j < NR; j++) begin
        e = '0;
        if (sv) begin
          e.v   = 1'b1;
          e.f   = (j < NR - 1) && (m_col == j);
          e.d.r = s_col_r[j*WD +: WD];
          e.d.i = s_col_i[j*WD +: WD];
        end
        sb_q[j].push_back(e);
      end
      if (sv) begin
        is_end = (m_col == NC - 1);
        if (last != is_end) m_err = 1'b1;
        m_col = (last || is_end) ? 0 : m_col + 1;
      end
    end
    @(posedge clk);
    #1;
    for (int j = 0; j < NR; j++) begin
      if (mr) held[j] = sb_q[j].pop_front();
      o = get_obs(j);
      chk("row", j, 64'(o), 64'(held[j]));
    end
    chk("err_frame", 0, 64'(err_frame), 64'(m_err));
  endtask

  task automatic do_reset(input logic sv);
    rst     = 1'b1;
    s_valid = sv;
    s_last  = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    chk("rst_valid", 0, 64'(m_row_valid), 64'(0));
    chk("rst_f", 0, 64'(m_row_f), 64'(0));
    chk("rst_r", 0, 64'(m_row_r), 64'(0));
    chk("rst_i", 0, 64'(m_row_i), 64'(0));
    chk("rst_err", 0, 64'(err_frame), 64'(0));
  endtask

  task automatic send_frame(input int off);
    for (int k = 0; k < NC; k++) step(1'b1, k, off, k == NC - 1, 1'b1);
  endtask

  task automatic flush(input int n);
    for (int b = 0; b < n; b++) step(1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    int yr [NR];
    int yi [NR];
    yr = '{181, 362, 543, 724};
    yi = '{724, 362, 543, 181};
    for (int j = 0; j < NR; j++) begin
      for (int k = 0; k < NR; k++) begin
        mat_r[j][k] = WD'((j + 1) * 1000 + k * 37);
        mat_i[j][k] = WD'(-(k + 1) * 500 - j * 11);
      end
      mat_r[j][NR] = WD'(yr[j]);
      mat_i[j][NR] = WD'(yi[j]);
    end
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    s_col_r = '0; s_col_i = '0;
    model_clear();

    // Reset with a column presented: reset wins.
    do_reset(1'b1);

    // Nominal frame with directed timing checks.
    for (int k = 0; k < NC; k++) begin
      step(1'b1, k, 0, k == NC - 1, 1'b1);
      if (k == 0) chk("nom_f_adv1", 0, 64'(m_row_f), 64'(3'b001));
      if (k == 2) chk("nom_f_adv3", 0, 64'(m_row_f), 64'(3'b010));
      if (k == 4) begin
        chk("nom_f_adv5", 0, 64'(m_row_f), 64'(3'b100));
        chk("nom_y_r", 0, 64'(m_row_r[WD-1:0]), 64'(14'd181));
        chk("nom_y_i", 0, 64'(m_row_i[WD-1:0]), 64'(14'd724));
      end
    end
    flush(NR);
    chk("nom_row3_idle", 0, 64'(m_row_valid), 64'(0));

    // Backpressure: stall 3 cycles after advance 2 with column 2 held on the input.
    step(1'b1, 0, 0, 1'b0, 1'b1);
    step(1'b1, 1, 0, 1'b0, 1'b1);
    for (int s = 0; s < 3; s++) step(1'b1, 2, 0, 1'b0, 1'b0);
    step(1'b1, 2, 0, 1'b0, 1'b1);
    step(1'b1, 3, 0, 1'b0, 1'b1);
    step(1'b1, 4, 0, 1'b1, 1'b1);
    flush(NR);

    // Mid-frame gap of two bubbles between columns 2 and 3.
    for (int k = 0; k < 3; k++) step(1'b1, k, 0, 1'b0, 1'b1);
    flush(2);
    step(1'b1, 3, 0, 1'b0, 1'b1);
    step(1'b1, 4, 0, 1'b1, 1'b1);
    flush(NR);

    // Back-to-back frames, second one offset by +1.
    send_frame(0);
    send_frame(1);
    flush(NR);

    // Frame error: s_last on column 2, then a complete frame.
    step(1'b1, 0, 0, 1'b0, 1'b1);
    step(1'b1, 1, 0, 1'b0, 1'b1);
    step(1'b1, 2, 0, 1'b1, 1'b1);
    chk("err_set", 0, 64'(err_frame), 64'(1));
    step(1'b1, 3, 0, 1'b0, 1'b1);
    chk("err_retag_f0", 0, 64'(m_row_f[0]), 64'(1));
    for (int k = 1; k < NC; k++) step(1'b1, k, 0, k == NC - 1, 1'b1);
    flush(NR);
    chk("err_sticky", 0, 64'(err_frame), 64'(1));

    // Reset mid-frame on what would be advance 3, then a fresh nominal frame.
    step(1'b1, 0, 0, 1'b0, 1'b1);
    step(1'b1, 1, 0, 1'b0, 1'b1);
    do_reset(1'b1);
    send_frame(0);
    flush(NR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
